// File: rtl/systolic_job_scheduler_if.sv
// ============================================================================
// Module      : systolic_job_scheduler_if
// Description : Signal bundle between the systolic job scheduler and its
//               environment (requesters, row fetch unit, MAC core, result
//               sink).
//   master modport : scheduler side (drives grant/status, fetch, core, sink)
//   slave  modport : environment side
//   Requesters : req_valid, req_gelu, req_keep_a, abort -> grant_id, busy,
//                job_done, job_err
//   Row fetch  : src_req, src_is_b, src_row <- src_ready
//   Core       : core_wr_en_a/b, core_wr_row, core_start, core_rd_row,
//                core_gelu_en <- core_done
//   Sink       : res_valid, res_row <- res_ready
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface systolic_job_scheduler_if #(
  parameter int ARRAY_SIZE = 32,
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1,
  parameter int REQ_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_gelu;
  logic [NUM_REQ-1:0]    req_keep_a;
  logic                  abort;
  logic [REQ_WIDTH-1:0]  grant_id;
  logic                  busy;
  logic [NUM_REQ-1:0]    job_done;
  logic [NUM_REQ-1:0]    job_err;
  logic                  src_req;
  logic                  src_is_b;
  logic [ADDR_WIDTH-1:0] src_row;
  logic                  src_ready;
  logic                  core_wr_en_a;
  logic                  core_wr_en_b;
  logic [ADDR_WIDTH-1:0] core_wr_row;
  logic                  core_start;
  logic                  core_done;
  logic [ADDR_WIDTH-1:0] core_rd_row;
  logic                  core_gelu_en;
  logic                  res_valid;
  logic [ADDR_WIDTH-1:0] res_row;
  logic                  res_ready;

  modport master (
    input  req_valid, req_gelu, req_keep_a, abort, src_ready, core_done, res_ready,
    output grant_id, busy, job_done, job_err, src_req, src_is_b, src_row,
           core_wr_en_a, core_wr_en_b, core_wr_row, core_start, core_rd_row,
           core_gelu_en, res_valid, res_row
  );

  modport slave (
    output req_valid, req_gelu, req_keep_a, abort, src_ready, core_done, res_ready,
    input  grant_id, busy, job_done, job_err, src_req, src_is_b, src_row,
           core_wr_en_a, core_wr_en_b, core_wr_row, core_start, core_rd_row,
           core_gelu_en, res_valid, res_row
  );
endinterface

`default_nettype wire

// File: rtl/systolic_job_scheduler.sv
// ============================================================================
// Module      : systolic_job_scheduler
// Description : Round-robin arbiter and job sequencer sharing one systolic
//               MAC core among NUM_REQ requesters. Per job: load A rows,
//               load B rows, pulse core start, wait for done (with timeout),
//               drain result rows to a backpressured sink.
// Ports       : clk    - clock
//               rst_n  - synchronous active-low reset
//               bus    - systolic_job_scheduler_if.master (requesters, row
//                        fetch, core control, result sink)
// Config      : SCHED_WEIGHT_REUSE_EN - when defined, a grant to the
//               requester whose job last completed skips the A load if that
//               requester asserts req_keep_a.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_job_scheduler #(
  parameter int ARRAY_SIZE     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ADDR_WIDTH     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1,
  parameter int REQ_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  systolic_job_scheduler_if.master  bus
);

  localparam int TMO_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ARRAY_SIZE - 1);
  localparam logic [TMO_WIDTH-1:0]  TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [REQ_WIDTH-1:0]  LAST_REQ = REQ_WIDTH'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_START   = 3'd3,
    S_COMPUTE = 3'd4,
    S_DRAIN   = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] row_cnt, row_nxt;
  logic [TMO_WIDTH-1:0]  tmo_cnt, tmo_nxt;
  logic [REQ_WIDTH-1:0]  grant_id_r, rr_ptr, rr_nxt;
  logic                  gelu_r;
  logic [NUM_REQ-1:0]    grant_onehot;

  logic                  arb_found;
  logic [REQ_WIDTH-1:0]  arb_sel, arb_cand;
  int                    arb_idx;

  logic                  grant_load;
  logic                  skip_a;
  logic                  end_ok, end_err;
  logic                  src_req, src_is_b, core_start, res_valid;
  logic [ADDR_WIDTH-1:0] src_row, rd_row;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_idx   = 0;
    arb_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_idx  = (int'(rr_ptr) + i) % NUM_REQ;
      arb_cand = REQ_WIDTH'(arb_idx);
      if (!arb_found && bus.req_valid[arb_cand]) begin
        arb_found = 1'b1;
        arb_sel   = arb_cand;
      end
    end
  end

  assign rr_nxt       = (arb_sel == LAST_REQ) ? '0 : arb_sel + 1'b1;
  assign grant_onehot = NUM_REQ'(1) << grant_id_r;

`ifdef SCHED_WEIGHT_REUSE_EN
  // A matrix stays resident in the core after a clean completion; any error,
  // abort or reset makes its contents untrustworthy.
  logic                 a_resident;
  logic [REQ_WIDTH-1:0] a_owner;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_resident <= 1'b0;
      a_owner    <= '0;
    end else if (end_err) begin
      a_resident <= 1'b0;
    end else if (end_ok) begin
      a_resident <= 1'b1;
      a_owner    <= grant_id_r;
    end
  end

  assign skip_a = bus.req_keep_a[arb_sel] && a_resident && (a_owner == arb_sel);
`else
  logic unused_keep_a;
  assign unused_keep_a = ^bus.req_keep_a;
  assign skip_a        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      row_cnt    <= '0;
      tmo_cnt    <= '0;
      grant_id_r <= '0;
      rr_ptr     <= '0;
      gelu_r     <= 1'b0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_nxt;
      tmo_cnt <= tmo_nxt;
      if (grant_load) begin
        grant_id_r <= arb_sel;
        rr_ptr     <= rr_nxt;
        gelu_r     <= bus.req_gelu[arb_sel];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    row_nxt    = row_cnt;
    tmo_nxt    = tmo_cnt;
    grant_load = 1'b0;
    end_ok     = 1'b0;
    end_err    = 1'b0;
    src_req    = 1'b0;
    src_is_b   = 1'b0;
    src_row    = '0;
    core_start = 1'b0;
    res_valid  = 1'b0;
    rd_row     = '0;

    case (state)
      S_IDLE: begin
        if (arb_found) begin
          grant_load = 1'b1;
          row_nxt    = '0;
          state_nxt  = skip_a ? S_LOAD_B : S_LOAD_A;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        src_req  = 1'b1;
        src_is_b = (state == S_LOAD_B);
        src_row  = row_cnt;
        if (bus.src_ready) begin
          if (row_cnt == LAST_ROW) begin
            row_nxt   = '0;
            state_nxt = (state == S_LOAD_A) ? S_LOAD_B : S_START;
          end else begin
            row_nxt = row_cnt + 1'b1;
          end
        end
      end
      S_START: begin
        core_start = 1'b1;
        tmo_nxt    = '0;
        state_nxt  = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (bus.core_done) begin
          row_nxt   = '0;
          state_nxt = S_DRAIN;
        end else if (tmo_cnt == TMO_LAST) begin
          end_err   = 1'b1;
          tmo_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        res_valid = 1'b1;
        rd_row    = row_cnt;
        if (bus.res_ready) begin
          if (row_cnt == LAST_ROW) begin
            row_nxt   = '0;
            state_nxt = S_FINISH;
          end else begin
            row_nxt = row_cnt + 1'b1;
          end
        end
      end
      S_FINISH: begin
        end_ok    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous core_done and a
    // pending start pulse.
    if (state != S_IDLE && bus.abort) begin
      state_nxt  = S_IDLE;
      row_nxt    = '0;
      tmo_nxt    = '0;
      end_ok     = 1'b0;
      end_err    = 1'b1;
      core_start = 1'b0;
    end

    // A reset cycle never reports job completion.
    if (!rst_n) begin
      end_ok  = 1'b0;
      end_err = 1'b0;
    end
  end

  assign bus.grant_id     = grant_id_r;
  assign bus.busy         = (state != S_IDLE);
  assign bus.job_done     = end_ok  ? grant_onehot : '0;
  assign bus.job_err      = end_err ? grant_onehot : '0;
  assign bus.src_req      = src_req;
  assign bus.src_is_b     = src_is_b;
  assign bus.src_row      = src_row;
  assign bus.core_wr_en_a = src_req & bus.src_ready & ~src_is_b;
  assign bus.core_wr_en_b = src_req & bus.src_ready &  src_is_b;
  assign bus.core_wr_row  = src_row;
  assign bus.core_start   = core_start;
  assign bus.core_rd_row  = rd_row;
  assign bus.core_gelu_en = gelu_r;
  assign bus.res_valid    = res_valid;
  assign bus.res_row      = rd_row;

endmodule

`default_nettype wire

// File: tb/tb_systolic_job_scheduler.sv
// ============================================================================
// Module      : tb_systolic_job_scheduler
// Description : Scoreboard bench for systolic_job_scheduler with N=4,
//               NUM_REQ=4, TIMEOUT_CYCLES=16 and a small behavioural core
//               that raises core_done 10 cycles after core_start.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_systolic_job_scheduler;
  localparam int N   = 4;
  localparam int NR  = 4;
  localparam int TMO = 16;
  localparam int AW  = 2;
  localparam int RW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_job_scheduler_if #(.ARRAY_SIZE(N), .NUM_REQ(NR), .ADDR_WIDTH(AW), .REQ_WIDTH(RW)) bus ();

  systolic_job_scheduler #(
    .ARRAY_SIZE(N), .NUM_REQ(NR), .TIMEOUT_CYCLES(TMO), .ADDR_WIDTH(AW), .REQ_WIDTH(RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int exp_grant[$];
  int exp_lat[$];
  int exp_wr[$];
  int exp_res[$];
  int exp_end[$];

  int cyc          = 0;
  int busy_rise    = 0;
  int start_cyc    = 0;
  int last_res_cyc = 0;
  int starts       = 0;
  int a_writes     = 0;
  int core_cnt     = 0;
  bit busy_q       = 1'b0;
  bit chk_tmo      = 1'b0;
  bit core_done_en = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core plus output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    bus.core_done = 1'b0;
    if (!rst_n || bus.job_err != '0) begin
      core_cnt = 0;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0 && core_done_en) bus.core_done = 1'b1;
    end
    if (bus.core_start) core_cnt = 10;

    if (rst_n) begin
      if (bus.busy && !busy_q) begin
        busy_rise = cyc;
        if (exp_grant.size() == 0) check_eq("grant_extra", 32'(bus.grant_id), 32'hFFFF_FFFF);
        else                       check_eq("grant_id", 32'(bus.grant_id), exp_grant.pop_front());
      end
      if (bus.core_wr_en_a || bus.core_wr_en_b) begin
        if (bus.core_wr_en_a) a_writes++;
        if (exp_wr.size() == 0) check_eq("wr_extra", 32'({bus.core_wr_en_b, bus.core_wr_row}), 32'hFFFF_FFFF);
        else                    check_eq("wr_row", 32'({bus.core_wr_en_b, bus.core_wr_row}), exp_wr.pop_front());
      end
      if (bus.core_start) begin
        starts++;
        start_cyc = cyc;
        if (exp_lat.size() == 0) check_eq("start_extra", cyc - busy_rise, 32'hFFFF_FFFF);
        else                     check_eq("start_lat", cyc - busy_rise, exp_lat.pop_front());
      end
      if (bus.res_valid && bus.res_ready) begin
        last_res_cyc = cyc;
        if (exp_res.size() == 0) check_eq("res_extra", 32'(bus.res_row), 32'hFFFF_FFFF);
        else                     check_eq("res_row", 32'(bus.res_row), exp_res.pop_front());
      end
      if (bus.job_done != '0 || bus.job_err != '0) begin
        if (exp_end.size() == 0) check_eq("end_extra", 32'({bus.job_err, bus.job_done}), 32'hFFFF_FFFF);
        else                     check_eq("job_end", 32'({bus.job_err, bus.job_done}), exp_end.pop_front());
        if (bus.job_done != '0) check_eq("done_lat", cyc - last_res_cyc, 1);
        if (bus.job_err != '0 && chk_tmo) check_eq("tmo_lat", cyc - start_cyc, TMO);
      end
    end
    busy_q = bus.busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_gelu = '0; bus.req_keep_a = '0;
    bus.abort = 1'b0; bus.src_ready = 1'b1; bus.res_ready = 1'b1;
    tick(); tick();
    exp_grant.delete(); exp_lat.delete(); exp_wr.delete(); exp_res.delete(); exp_end.delete();
    rst_n = 1'b1;
  endtask

  // Expected trace of one job granted to g; tmo selects timeout ending.
  task automatic push_job(input int g, input bit load_a, input bit tmo);
    exp_grant.push_back(g);
    exp_lat.push_back(load_a ? 2 * N : N);
    if (load_a) for (int r = 0; r < N; r++) exp_wr.push_back(r);
    for (int r = 0; r < N; r++) exp_wr.push_back(N + r);
    if (!tmo) for (int r = 0; r < N; r++) exp_res.push_back(r);
    exp_end.push_back(tmo ? (1 << (g + NR)) : (1 << g));
  endtask

  task automatic wait_end();
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (bus.job_done != '0 || bus.job_err != '0) got = 1'b1;
    end
    if (!got) check_eq("end_wait", 32'({bus.job_err, bus.job_done}), 32'hFFFF_FFFF);
  endtask

  task automatic check_drained();
    check_eq("q_left", exp_grant.size() + exp_lat.size() + exp_wr.size() + exp_res.size() + exp_end.size(), 0);
  endtask

  task automatic run_job(input logic [NR-1:0] mask);
    bus.req_valid = mask;
    wait_end();
    bus.req_valid = '0;
    tick(); tick();
    check_drained();
  endtask

  initial begin
    bus.core_done = 1'b0;
    do_reset();
    check_eq("rst_grant", 32'(bus.grant_id), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_out", 32'({bus.job_done, bus.job_err, bus.src_req, bus.core_start,
                             bus.res_valid, bus.core_gelu_en, bus.core_wr_en_a}), 0);

    // Single job, requester 1, GeLU selected.
    bus.req_gelu = 4'b0010;
    push_job(1, 1'b1, 1'b0);
    bus.req_valid = 4'b0010;
    wait_end();
    check_eq("gelu_en", 32'(bus.core_gelu_en), 1);
    bus.req_valid = '0;
    tick(); tick();
    check_drained();
    bus.req_gelu = '0;

    // All requesters held: round-robin from pointer 0.
    do_reset();
    push_job(0, 1'b1, 1'b0); push_job(1, 1'b1, 1'b0); push_job(2, 1'b1, 1'b0);
    bus.req_valid = 4'b1111;
    wait_end();
    check_eq("gelu_off", 32'(bus.core_gelu_en), 0);
    wait_end(); wait_end();
    bus.req_valid = '0;
    tick(); tick();
    check_drained();

    do_reset();
    push_job(0, 1'b1, 1'b0); push_job(3, 1'b1, 1'b0); push_job(0, 1'b1, 1'b0);
    bus.req_valid = 4'b1001;
    wait_end(); wait_end(); wait_end();
    bus.req_valid = '0;
    tick(); tick();
    check_drained();

    // Sink backpressure at row 2.
    push_job(2, 1'b1, 1'b0);
    bus.req_valid = 4'b0100;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        tick();
        if (bus.res_valid && bus.res_row == 2'd2) hit = 1'b1;
      end
      if (!hit) check_eq("stall_wait", 32'(bus.res_row), 32'hFFFF_FFFF);
    end
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_valid", 32'(bus.res_valid), 1);
      check_eq("stall_row", 32'(bus.res_row), 2);
    end
    bus.res_ready = 1'b1;
    wait_end();
    bus.req_valid = '0;
    tick(); tick();
    check_drained();

    // Core never finishes: timeout error.
    core_done_en = 1'b0;
    chk_tmo      = 1'b1;
    push_job(0, 1'b1, 1'b1);
    run_job(4'b0001);
    check_eq("tmo_idle", 32'(bus.busy), 0);
    core_done_en = 1'b1;
    chk_tmo      = 1'b0;

    // Abort in LOAD_B row 1: no start, restart from A row 0 afterwards.
    starts = 0;
    exp_grant.push_back(1);
    for (int r = 0; r < N; r++) exp_wr.push_back(r);
    exp_wr.push_back(N);
    exp_end.push_back(1 << (1 + NR));
    bus.req_valid = 4'b0010;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        tick();
        if (bus.src_req && bus.src_is_b && bus.src_row == 2'd1) hit = 1'b1;
      end
      if (!hit) check_eq("abort_wait", 32'(bus.src_row), 32'hFFFF_FFFF);
    end
    bus.abort = 1'b1; bus.src_ready = 1'b0; bus.req_valid = '0;
    tick();
    bus.abort = 1'b0; bus.src_ready = 1'b1;
    tick(); tick();
    check_eq("abort_no_start", starts, 0);
    check_eq("abort_idle", 32'(bus.busy), 0);
    check_drained();

    bus.abort = 1'b1;
    #1;
    check_eq("idle_abort_err", 32'(bus.job_err), 0);
    tick();
    bus.abort = 1'b0;
    check_eq("idle_abort_busy", 32'(bus.busy), 0);

    push_job(1, 1'b1, 1'b0);
    run_job(4'b0010);

    // Back-to-back jobs from requester 2 with keep_a.
    do_reset();
    bus.req_keep_a = 4'b0100;
    push_job(2, 1'b1, 1'b0);
    run_job(4'b0100);
    a_writes = 0;
`ifdef SCHED_WEIGHT_REUSE_EN
    push_job(2, 1'b0, 1'b0);
    run_job(4'b0100);
    check_eq("reuse_a_writes", a_writes, 0);
`else
    push_job(2, 1'b1, 1'b0);
    run_job(4'b0100);
    check_eq("reuse_a_writes", a_writes, N);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
